// File: rtl/banco_reg_sb.sv
// banco_reg_sb: register bank with two combinational read ports, one synchronous
// write port, an optional write-to-read bypass, an optional hardwired-zero
// register 0, and a per-register pending-write scoreboard.
//   - Decode reserves a destination register with Reserve/RAres.
//   - Writeback clears that reservation through the normal write port.
//   - Busy1/Busy2 report the pending state of the registers being read.
//   - PendCnt is the number of registers currently pending.
//   - ResErr flags a reservation of a register that is already pending.
module banco_reg_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] AW,
    input  logic [DATA_W-1:0] Di,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] DR1,
    output logic [DATA_W-1:0] DR2,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] RAres,
    output logic              Busy1,
    output logic              Busy2,
    output logic [ADDR_W:0]   PendCnt,
    output logic              ResErr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              reserr_q, reserr_d;

    logic wr_en;
    logic res_en;
    logic cnt_inc;
    logic cnt_dec;

    // Writes and reservations aimed at the hardwired-zero register are dropped here,
    // so nothing downstream needs to special-case address 0 again.
    assign wr_en  = RegWrite && !((ZERO_REG != 0) && (AW == '0));
    assign res_en = Reserve  && !((ZERO_REG != 0) && (RAres == '0));

    // One read port: returns {busy, data}.
    // Reset and the zero register force both fields to 0.
    // The bypass forwards Di and also hides the busy flag of the register being
    // written back, unless that register is being reserved again in this cycle.
    function automatic logic [DATA_W:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] word,
        input logic              pbit,
        input logic              w_en,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic              r_en,
        input logic [ADDR_W-1:0] raddr,
        input logic              in_rst
    );
        logic [DATA_W-1:0] data;
        logic              busy;
        data = word;
        busy = pbit;
        if ((BYPASS != 0) && w_en && (waddr == ra)) begin
            data = wdata;
            if (!(r_en && (raddr == ra))) begin
                busy = 1'b0;
            end
        end
        if (in_rst || ((ZERO_REG != 0) && (ra == '0))) begin
            data = '0;
            busy = 1'b0;
        end
        return {busy, data};
    endfunction

    assign {Busy1, DR1} = read_port(RA1, mem_q[RA1], pend_q[RA1], wr_en, AW, Di,
                                    res_en, RAres, rst);
    assign {Busy2, DR2} = read_port(RA2, mem_q[RA2], pend_q[RA2], wr_en, AW, Di,
                                    res_en, RAres, rst);

    // Next-state logic for the scoreboard.
    // A reserve and a clear on the same register in the same cycle resolve to "set".
    // The counter tracks the population of pend bits incrementally.
    always_comb begin
        pend_d   = pend_q;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        reserr_d = 1'b0;

        if (wr_en) begin
            pend_d[AW] = 1'b0;
        end
        if (res_en) begin
            pend_d[RAres] = 1'b1;
        end

        // Only a register that was clear can be newly set.
        cnt_inc = res_en && !pend_q[RAres];
        // Only a register that was pending can be cleared.
        // A clear does not count when the same register is re-reserved in this cycle.
        cnt_dec = wr_en && pend_q[AW] && !(res_en && (RAres == AW));
        cnt_d   = cnt_q + (ADDR_W + 1)'(cnt_inc) - (ADDR_W + 1)'(cnt_dec);

        // Reserving a pending register is an error unless writeback frees it on this edge.
        reserr_d = res_en && pend_q[RAres] && !(wr_en && (AW == RAres));
    end

    // Register storage: asynchronous clear, single synchronous write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            mem_q[AW] <= Di;
        end
    end

    // Scoreboard state: pend bits, pending count and the one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            cnt_q    <= '0;
            reserr_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            reserr_q <= reserr_d;
        end
    end

    assign PendCnt = cnt_q;
    assign ResErr  = reserr_q;

endmodule

// File: tb/tb_banco_reg_sb.sv
// Testbench for banco_reg_sb.
// Two instances share the same stimulus:
//   - instance 0 uses the defaults (zero register and bypass on);
//   - instance 1 has both features off.
// A behavioural model (plain arrays per instance) supplies every expected value.
module tb_banco_reg_sb;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite, Reserve;
    logic [4:0]  AW, RA1, RA2, RAres;
    logic [31:0] Di;

    logic [31:0] dr1 [2];
    logic [31:0] dr2 [2];
    logic        bz1 [2];
    logic        bz2 [2];
    logic [5:0]  cnt [2];
    logic        rer [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem  [2][N];
    bit          m_pend [2][N];
    bit          m_re   [2];

    always #5 clk = ~clk;

    banco_reg_sb u_dut (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .AW(AW), .Di(Di),
        .RA1(RA1), .RA2(RA2), .DR1(dr1[0]), .DR2(dr2[0]),
        .Reserve(Reserve), .RAres(RAres), .Busy1(bz1[0]), .Busy2(bz2[0]),
        .PendCnt(cnt[0]), .ResErr(rer[0])
    );

    banco_reg_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_plain (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .AW(AW), .Di(Di),
        .RA1(RA1), .RA2(RA2), .DR1(dr1[1]), .DR2(dr2[1]),
        .Reserve(Reserve), .RAres(RAres), .Busy1(bz1[1]), .Busy2(bz2[1]),
        .PendCnt(cnt[1]), .ResErr(rer[1])
    );

    // Instance 0 has zero register and bypass; instance 1 has neither.
    function automatic bit has_zero(int k);
        return k == 0;
    endfunction

    function automatic bit has_byp(int k);
        return k == 0;
    endfunction

    function automatic bit eff_wr(int k);
        return RegWrite && !(has_zero(k) && AW == 5'd0);
    endfunction

    function automatic bit eff_res(int k);
        return Reserve && !(has_zero(k) && RAres == 5'd0);
    endfunction

    function automatic logic [31:0] exp_dr(int k, logic [4:0] ra);
        if (rst) return 32'd0;
        if (has_zero(k) && ra == 5'd0) return 32'd0;
        if (has_byp(k) && eff_wr(k) && AW == ra) return Di;
        return m_mem[k][ra];
    endfunction

    function automatic logic [31:0] exp_busy(int k, logic [4:0] ra);
        if (rst) return 32'd0;
        if (has_zero(k) && ra == 5'd0) return 32'd0;
        if (has_byp(k) && eff_wr(k) && AW == ra && !(eff_res(k) && RAres == ra))
            return 32'd0;
        return {31'd0, m_pend[k][ra]};
    endfunction

    function automatic logic [31:0] exp_cnt(int k);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_pend[k][i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                m_mem[k][i]  = 32'd0;
                m_pend[k][i] = 1'b0;
            end
            m_re[k] = 1'b0;
        end
    endtask

    // Apply one rising edge to the model using the inputs that were present before it.
    task automatic model_edge();
        bit re_new;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            re_new = eff_res(k) && m_pend[k][RAres] && !(eff_wr(k) && AW == RAres);
            if (eff_wr(k)) begin
                m_mem[k][AW]  = Di;
                m_pend[k][AW] = 1'b0;
            end
            if (eff_res(k)) m_pend[k][RAres] = 1'b1;
            m_re[k] = re_new;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string ctx);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s/u%0d/DR1", ctx, k), dr1[k], exp_dr(k, RA1));
            chk($sformatf("%s/u%0d/DR2", ctx, k), dr2[k], exp_dr(k, RA2));
            chk($sformatf("%s/u%0d/Busy1", ctx, k), {31'd0, bz1[k]}, exp_busy(k, RA1));
            chk($sformatf("%s/u%0d/Busy2", ctx, k), {31'd0, bz2[k]}, exp_busy(k, RA2));
            chk($sformatf("%s/u%0d/PendCnt", ctx, k), {26'd0, cnt[k]}, exp_cnt(k));
            chk($sformatf("%s/u%0d/ResErr", ctx, k), {31'd0, rer[k]}, {31'd0, m_re[k]});
        end
    endtask

    // Called just after a falling edge: drive, check combinational view, take the edge.
    task automatic step(input logic rw, input logic [4:0] aw, input logic [31:0] di,
                        input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic res, input logic [4:0] rares, input string ctx);
        RegWrite = rw;
        AW       = aw;
        Di       = di;
        RA1      = ra1;
        RA2      = ra2;
        Reserve  = res;
        RAres    = rares;
        #1;
        check_all(ctx);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] a1, a2, aw, ar;

        // Reset, with a write aimed at the read address to prove reads stay 0 in reset.
        rst      = 1'b1;
        RegWrite = 1'b1;
        AW       = 5'd3;
        Di       = 32'hFFFF_FFFF;
        RA1      = 5'd3;
        RA2      = 5'd3;
        Reserve  = 1'b1;
        RAres    = 5'd3;
        model_reset();
        @(negedge clk);
        #1;
        check_all("in_reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < N; i++) begin
            step(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b0, 5'd0, "rd_after_reset");
        end

        // Plain writes, then reads on the following cycle.
        step(1'b1, 5'd21, 32'd25, 5'd0, 5'd0, 1'b0, 5'd0, "wr21");
        step(1'b1, 5'd22, 32'd35, 5'd21, 5'd0, 1'b0, 5'd0, "wr22");
        step(1'b1, 5'd23, 32'd45, 5'd22, 5'd21, 1'b0, 5'd0, "wr23");
        step(1'b0, 5'd0, 32'd0, 5'd21, 5'd23, 1'b0, 5'd0, "rd21_23");

        // Bypass: u0 shows Di before the edge, u1 still shows 35.
        step(1'b1, 5'd22, 32'hDEADBEEF, 5'd22, 5'd23, 1'b0, 5'd0, "bypass22");
        step(1'b0, 5'd0, 32'd0, 5'd22, 5'd22, 1'b0, 5'd0, "rd22");

        // Register 0: dropped and ignored in u0, ordinary register in u1.
        step(1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 1'b0, 5'd0, "wr0");
        step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0, "res0");
        step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0, "res0_again");
        step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, "after_res0");
        step(1'b1, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, "clr0");

        // Scoreboard sequence on register 5.
        step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1, 5'd5, "res5");
        step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1, 5'd5, "res5_again");
        step(1'b1, 5'd5, 32'h55, 5'd5, 5'd5, 1'b1, 5'd5, "wr5_res5");
        step(1'b1, 5'd5, 32'h66, 5'd5, 5'd6, 1'b0, 5'd0, "wr5");
        step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0, "after_wr5");
        // Reserve and clear on different registers: net count change 0.
        step(1'b0, 5'd0, 32'd0, 5'd7, 5'd8, 1'b1, 5'd7, "res7");
        step(1'b1, 5'd7, 32'h77, 5'd7, 5'd8, 1'b1, 5'd8, "wr7_res8");
        step(1'b1, 5'd8, 32'h88, 5'd7, 5'd8, 1'b0, 5'd0, "wr8");

        // Reserve 3, 4, 6, then reset in mid-cycle with a write/reserve pending.
        step(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd3, "res3");
        step(1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 1'b1, 5'd4, "res4");
        step(1'b0, 5'd0, 32'd0, 5'd3, 5'd6, 1'b1, 5'd6, "res6");
        step(1'b0, 5'd0, 32'd0, 5'd4, 5'd6, 1'b1, 5'd4, "res4_err");
        RegWrite = 1'b1;
        AW       = 5'd21;
        Di       = 32'hCAFE;
        RA1      = 5'd3;
        RA2      = 5'd21;
        Reserve  = 1'b1;
        RAres    = 5'd9;
        #1;
        check_all("pre_midrst");
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("midrst");
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 5'd0, 32'd0, 5'(i * 4), 5'(i * 4 + 1), 1'b0, 5'd0, "post_midrst");
        end

        // Randomised traffic on a small address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            if (i % 4 == 0) begin
                a1 = 5'($urandom_range(0, 31));
                aw = 5'($urandom_range(0, 31));
            end else begin
                a1 = 5'($urandom_range(0, 7));
                aw = 5'($urandom_range(0, 7));
            end
            a2 = 5'($urandom_range(0, 7));
            ar = 5'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), aw, $urandom, a1, a2,
                 1'($urandom_range(0, 1)), ar, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
